// File: rtl/riscv_rf_pkg.sv
// rtl/riscv_rf_pkg.sv - shared constants for the multi-port integer register file
package riscv_rf_pkg;
  localparam int RF_ADDR_WIDTH = 5;
  localparam int RF_DATA_WIDTH = 32;
  localparam int ZERO_ADDR     = 0;
  localparam int MAX_RD_PORTS  = 4;
  localparam int MAX_WR_PORTS  = 2;
endpackage

// File: rtl/rf_write_arbiter.sv
// rtl/rf_write_arbiter.sv - per-register winning write port and data
module rf_write_arbiter
  import riscv_rf_pkg::*;
#(
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int DATA_WIDTH = RF_DATA_WIDTH,
  parameter int NUM_WR     = 2,
  parameter int ZERO_REG   = 1
) (
  input  logic [NUM_WR-1:0]                           we,
  input  logic [NUM_WR*ADDR_WIDTH-1:0]                wa,
  input  logic [NUM_WR*DATA_WIDTH-1:0]                wd,
  output logic [2**ADDR_WIDTH-1:0]                    hit,
  output logic [2**ADDR_WIDTH-1:0][DATA_WIDTH-1:0]    data
);
  localparam int DEPTH = 2**ADDR_WIDTH;

  // Later ports overwrite earlier ones, so the highest-index match wins.
  always_comb begin
    hit  = '0;
    data = '0;
    for (int r = 0; r < DEPTH; r++) begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (we[w] && (wa[w*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(r)) &&
            !((ZERO_REG != 0) && (r == ZERO_ADDR))) begin
          hit[r]  = 1'b1;
          data[r] = wd[w*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end
endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with bypass and pending scoreboard
module regfile_mp
  import riscv_rf_pkg::*;
#(
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int DATA_WIDTH = RF_DATA_WIDTH,
  parameter int NUM_RD     = 3,
  parameter int NUM_WR     = 2,
  parameter int BYPASS     = 1,
  parameter int ZERO_REG   = 1
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] RA,
  output logic [NUM_RD*DATA_WIDTH-1:0] RD,
  output logic [NUM_RD-1:0]            RD_PEND,
  input  logic [NUM_WR-1:0]            WE,
  input  logic [NUM_WR*ADDR_WIDTH-1:0] WA,
  input  logic [NUM_WR*DATA_WIDTH-1:0] WD,
  input  logic                         ISSUE_EN,
  input  logic [ADDR_WIDTH-1:0]        ISSUE_ADDR,
  output logic [ADDR_WIDTH:0]          PEND_CNT
);
  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;

  if (NUM_RD < 1 || NUM_RD > MAX_RD_PORTS || NUM_WR < 1 || NUM_WR > MAX_WR_PORTS) begin : g_bad_ports
    $error("regfile_mp: unsupported NUM_RD/NUM_WR");
  end

  logic [DEPTH-1:0][DATA_WIDTH-1:0] regs;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] wr_data;
  logic [DEPTH-1:0]                 wr_hit;
  logic [DEPTH-1:0]                 issue_hit;
  logic [DEPTH-1:0]                 pend;
  logic [DEPTH-1:0]                 pend_next;
  logic [CW-1:0]                    pend_cnt_q;
  logic [CW-1:0]                    cnt_next;
  logic [CW-1:0]                    n_set;
  logic [CW-1:0]                    n_clr;
  logic [NUM_RD-1:0][ADDR_WIDTH-1:0] ra;

  assign ra       = RA;
  assign PEND_CNT = pend_cnt_q;

  rf_write_arbiter #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_WR     (NUM_WR),
    .ZERO_REG   (ZERO_REG)
  ) u_arb (
    .we   (WE),
    .wa   (WA),
    .wd   (WD),
    .hit  (wr_hit),
    .data (wr_data)
  );

  always_comb begin
    issue_hit = '0;
    for (int r = 0; r < DEPTH; r++) begin
      if (ISSUE_EN && (ISSUE_ADDR == ADDR_WIDTH'(r)) &&
          !((ZERO_REG != 0) && (r == ZERO_ADDR)))
        issue_hit[r] = 1'b1;
    end
  end

  // A new producer supersedes a completing write to the same register.
  always_comb begin
    pend_next = issue_hit | (pend & ~wr_hit);
    n_set     = '0;
    n_clr     = '0;
    for (int r = 0; r < DEPTH; r++) begin
      if (pend_next[r] && !pend[r]) n_set = n_set + CW'(1);
      if (!pend_next[r] && pend[r]) n_clr = n_clr + CW'(1);
    end
    cnt_next = pend_cnt_q + n_set - n_clr;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      regs       <= '0;
      pend       <= '0;
      pend_cnt_q <= '0;
    end else begin
      for (int r = 0; r < DEPTH; r++) begin
        if (wr_hit[r]) regs[r] <= wr_data[r];
      end
      pend       <= pend_next;
      pend_cnt_q <= cnt_next;
    end
  end

  // Outputs are forced to zero while reset is held, bypass included.
  always_comb begin
    RD      = '0;
    RD_PEND = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      if (RST_N && !((ZERO_REG != 0) && (ra[i] == ADDR_WIDTH'(ZERO_ADDR)))) begin
        if ((BYPASS != 0) && wr_hit[ra[i]]) begin
          RD[i*DATA_WIDTH +: DATA_WIDTH] = wr_data[ra[i]];
          RD_PEND[i]                     = pend[ra[i]] & issue_hit[ra[i]];
        end else begin
          RD[i*DATA_WIDTH +: DATA_WIDTH] = regs[ra[i]];
          RD_PEND[i]                     = pend[ra[i]];
        end
      end
    end
  end
endmodule
